conv_pool_engine: RTL and testbench
===================================

// Module: conv_pool_engine
// PURPOSE
//  Parametrised 3x3 convolution + bias + ReLU engine with optional 2x2 max-pool.
//  Reads an IMG_W x IMG_H signed fixed-point image from image ROM (iaddr/idata).
//  Writes the layer-0 map (csel=001) and, if pooling is enabled, the layer-1 map (csel=011).
//  Kernel and bias are runtime-loadable through a coefficient port.
// PARAMETERS
//  IMG_W   64  image width in pixels; even and >=2 when pooling
//  IMG_H   64  image height in pixels; even and >=2 when pooling
//  DW      20  data/coef width, signed, FRAC fractional bits
//  FRAC    16  fractional bits of data, coefficients and bias
//  ADDR_W  12  address width; >= clog2(IMG_W*IMG_H)
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high
//  ready      in   1       start request, sampled only while busy=0
//  busy       out  1       high from start until final write completes
//  pool_en    in   1       1: conv+pool, 0: conv only; sampled at start
//  coef_we    in   1       coefficient write strobe, honoured only while busy=0
//  coef_idx   in   4       0..8 kernel taps, row-major (0=(-1,-1), 8=(+1,+1)); 9=bias; 10..15 ignored
//  coef_data  in   DW      signed coefficient value
//  iaddr      out  ADDR_W  image address; idata valid 1 cycle later
//  idata      in   DW      signed image pixel
//  cwr        out  1       map write strobe, 1 cycle per word
//  caddr_wr   out  ADDR_W  map write address
//  cdata_wr   out  DW      map write data
//  crd        out  1       map read strobe
//  caddr_rd   out  ADDR_W  map read address; cdata_rd valid 1 cycle later
//  cdata_rd   in   DW      map read data
//  csel       out  3       000 idle, 001 layer 0, 011 layer 1
// BEHAVIOUR
//  - Reset: every output, coefficient register, counter and state goes to 0; state -> IDLE.
//    Reset mid-run aborts the run with no further writes.
//  - FSM states: IDLE -> CONV -> POOL -> IDLE.
//    CONV -> IDLE directly when pool_en=0.
//  - IDLE: ready=1 moves to CONV on the next edge and raises busy. ready is ignored while busy.
//  - CONV: pixels are processed in raster order, addr=y*IMG_W+x. Each pixel takes exactly 12 cycles:
//    - cycles 1-9: issue one tap address per cycle;
//    - MAC of each tap occurs 1 cycle after its address is issued;
//    - cycle 11: bias/round/saturate/ReLU;
//    - cycle 12: cwr=1, csel=001, caddr_wr=addr.
//  - Padding: taps outside the image contribute 0 but still take their cycle. The iaddr value for
//    such taps is don't-care.
//  - Arithmetic: the accumulator is signed 2*DW+4 bits.
//    - sum = acc + (bias<<FRAC) + 2^(FRAC-1), i.e. round half up.
//    - r = sum>>>FRAC.
//    - r > 2^(DW-1)-1 saturates to 2^(DW-1)-1; r < 0 gives 0 (ReLU).
//  - POOL: one output per (px,py), raster over IMG_W/2 x IMG_H/2. Each output takes exactly 6 cycles:
//    - cycles 1-4: crd=1, csel=001, read (2px,2py), (2px+1,2py), (2px,2py+1), (2px+1,2py+1);
//    - max is an unsigned compare with initial value 0;
//    - cycle 6: cwr=1, csel=011, caddr_wr=py*(IMG_W/2)+px.
//  - Cycle count: busy falls on the edge ending the last cwr cycle, and cwr/crd/csel return to 0 on
//    that same edge. Busy-high duration is IMG_W*IMG_H*12 + (pool_en ? IMG_W*IMG_H/4*6 : 0) cycles.
//  - cwr and crd are never high together. Write strobes outside the stated cycles are 0.
//  - Coefficients hold their value across runs. coef_we during busy has no effect.
// TESTING
//  - Taps 0, bias=0x01000, idata=0, pool_en=1 -> all 4096 L0 and 1024 L1 words = 0x01000;
//    busy high for exactly 55296 cycles.
//  - Tap4=0x10000, others 0, bias 0, idata[a]=a (non-negative) -> L0[a]=a for all a,
//    including corners 0, 63, 4032, 4095.
//  - All taps 0x10000, idata=0x10000 -> corners 0x40000, edges 0x60000, interior saturates 0x7FFFF;
//    L1[0]=0x7FFFF.
//  - Tap4=0xF0000, idata=0x10000 -> L0 all 0 (ReLU).
//    Tap4=0x08000, idata=0x00001 -> L0=0x00001 (round half up).
//  - pool_en=0 -> no csel=011 write, busy high 49152 cycles.
//    coef_we pulse during busy -> results unchanged.
//  - Reset asserted at pixel 100 -> outputs 0 and busy 0 immediately.
//    Reloading coefficients and pulsing ready restarts from pixel 0 with correct results.

Source files
------------

// File: rtl/conv_pool_engine.sv
// 3x3 convolution + bias + round + saturate + ReLU engine with optional 2x2 max-pool.
// The layer-0 map is written with csel=001 and the pooled layer-1 map with csel=011.
module conv_pool_engine #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int DW     = 20,
    parameter int FRAC   = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    output logic              busy,
    input  logic              pool_en,
    input  logic              coef_we,
    input  logic [3:0]        coef_idx,
    input  logic [DW-1:0]     coef_data,
    output logic [ADDR_W-1:0] iaddr,
    input  logic [DW-1:0]     idata,
    output logic              cwr,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [DW-1:0]     cdata_wr,
    output logic              crd,
    output logic [ADDR_W-1:0] caddr_rd,
    input  logic [DW-1:0]     cdata_rd,
    output logic [2:0]        csel
);

    localparam int ACC_W = 2*DW + 4;
    localparam int CW    = ADDR_W + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_POOL = 2'd2;

    localparam logic [CW-1:0]     W_C      = CW'(IMG_W);
    localparam logic [CW-1:0]     H_C      = CW'(IMG_H);
    localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] LAST_X   = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W*IMG_H - 1);
    localparam logic [ADDR_W-1:0] LAST_PX  = ADDR_W'(IMG_W/2 - 1);
    localparam logic [ADDR_W-1:0] LAST_PO  = ADDR_W'((IMG_W/2)*(IMG_H/2) - 1);

    localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(2**(FRAC-1));
    localparam logic signed [ACC_W-1:0] MAXV  = ACC_W'(2**(DW-1) - 1);

    logic [1:0]               state;
    logic [3:0]               ph;
    logic                     pool_r;
    logic signed [DW-1:0]     kern [0:8];
    logic signed [DW-1:0]     bias;

    logic [ADDR_W-1:0]        x_cnt;
    logic [ADDR_W-1:0]        y_cnt;
    logic [ADDR_W-1:0]        pix_addr;
    logic                     tap_ok_d;
    logic signed [DW-1:0]     coef_d;
    logic signed [ACC_W-1:0]  acc;
    logic [DW-1:0]            result;

    logic [ADDR_W-1:0]        px;
    logic [ADDR_W-1:0]        qbase;
    logic [ADDR_W-1:0]        paddr;
    logic [DW-1:0]            max_r;

    logic [1:0]               tap_row;
    logic [1:0]               tap_col;
    logic [CW-1:0]            tap_x;
    logic [CW-1:0]            tap_y;
    logic                     tap_ok;
    logic [ADDR_W-1:0]        tap_addr;

    logic signed [2*DW-1:0]   prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  shifted;
    logic [DW-1:0]            relu_val;

    // Tap geometry: an off-image neighbour wraps to a huge unsigned value, so one compare catches both sides.
    always_comb begin
        tap_row  = (ph >= 4'd6) ? 2'd2 : (ph >= 4'd3) ? 2'd1 : 2'd0;
        tap_col  = (ph == 4'd1 || ph == 4'd4 || ph == 4'd7) ? 2'd1 :
                   (ph == 4'd2 || ph == 4'd5 || ph == 4'd8) ? 2'd2 : 2'd0;
        tap_x    = CW'(x_cnt) + CW'(tap_col) - CW'(1);
        tap_y    = CW'(y_cnt) + CW'(tap_row) - CW'(1);
        tap_ok   = (tap_x < W_C) && (tap_y < H_C);
        tap_addr = ADDR_W'(tap_y) * W_A + ADDR_W'(tap_x);
    end

    always_comb begin
        prod     = $signed(idata) * coef_d;
        prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
        sum      = acc + (ACC_W'(bias) <<< FRAC) + ROUND;
        shifted  = sum >>> FRAC;
        if (shifted[ACC_W-1]) begin
            relu_val = '0;
        end else if (shifted > MAXV) begin
            relu_val = MAXV[DW-1:0];
        end else begin
            relu_val = shifted[DW-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            ph       <= '0;
            pool_r   <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                kern[i] <= '0;
            end
            bias     <= '0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            pix_addr <= '0;
            tap_ok_d <= 1'b0;
            coef_d   <= '0;
            acc      <= '0;
            result   <= '0;
            px       <= '0;
            qbase    <= '0;
            paddr    <= '0;
            max_r    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (coef_we) begin
                        if (coef_idx < 4'd9) begin
                            kern[coef_idx] <= coef_data;
                        end else if (coef_idx == 4'd9) begin
                            bias <= coef_data;
                        end
                    end
                    if (ready) begin
                        state    <= S_CONV;
                        pool_r   <= pool_en;
                        ph       <= '0;
                        x_cnt    <= '0;
                        y_cnt    <= '0;
                        pix_addr <= '0;
                    end
                end

                // Twelve-phase pixel: taps at 0-8, MACs trail by one at 1-9, finish at 10, write at 11.
                S_CONV: begin
                    tap_ok_d <= tap_ok;
                    coef_d   <= (ph < 4'd9) ? kern[ph] : '0;
                    if (ph == 4'd0) begin
                        acc <= '0;
                    end else if (ph <= 4'd9) begin
                        acc <= acc + (tap_ok_d ? prod_ext : '0);
                    end
                    if (ph == 4'd10) begin
                        result <= relu_val;
                    end
                    if (ph == 4'd11) begin
                        ph       <= '0;
                        pix_addr <= pix_addr + 1'b1;
                        if (x_cnt == LAST_X) begin
                            x_cnt <= '0;
                            y_cnt <= y_cnt + 1'b1;
                        end else begin
                            x_cnt <= x_cnt + 1'b1;
                        end
                        if (pix_addr == LAST_PIX) begin
                            state <= pool_r ? S_POOL : S_IDLE;
                            px    <= '0;
                            qbase <= '0;
                            paddr <= '0;
                        end
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end

                // Six-phase pool output: reads at 0-3, compares trail by one at 1-4, write at 5.
                S_POOL: begin
                    if (ph == 4'd0) begin
                        max_r <= '0;
                    end else if (ph <= 4'd4 && cdata_rd > max_r) begin
                        max_r <= cdata_rd;
                    end
                    if (ph == 4'd5) begin
                        ph    <= '0;
                        paddr <= paddr + 1'b1;
                        if (px == LAST_PX) begin
                            px    <= '0;
                            qbase <= qbase + W_A + ADDR_W'(2);
                        end else begin
                            px    <= px + 1'b1;
                            qbase <= qbase + ADDR_W'(2);
                        end
                        if (paddr == LAST_PO) begin
                            state <= S_IDLE;
                        end
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state so an asynchronous reset silences them at once.
    always_comb begin
        busy     = (state != S_IDLE);
        cwr      = ((state == S_CONV) && (ph == 4'd11)) || ((state == S_POOL) && (ph == 4'd5));
        crd      = (state == S_POOL) && (ph < 4'd4);
        iaddr    = ((state == S_CONV) && (ph < 4'd9) && tap_ok) ? tap_addr : '0;
        caddr_rd = crd ? (qbase + (ph[1] ? W_A : '0) + ADDR_W'(ph[0])) : '0;
        caddr_wr = '0;
        cdata_wr = '0;
        csel     = 3'b000;
        if (state == S_CONV) begin
            csel = 3'b001;
            if (cwr) begin
                caddr_wr = pix_addr;
                cdata_wr = result;
            end
        end else if (state == S_POOL) begin
            csel = (ph == 4'd5) ? 3'b011 : 3'b001;
            if (cwr) begin
                caddr_wr = paddr;
                cdata_wr = max_r;
            end
        end
    end

endmodule

// File: tb/tb_conv_pool_engine.sv
// Randomised and directed bench for conv_pool_engine on a small 8x6 image,
// checked against an arithmetic model of the convolution and pooling rules.
module tb_conv_pool_engine;

    localparam int W     = 8;
    localparam int H     = 6;
    localparam int DW    = 20;
    localparam int FRAC  = 16;
    localparam int AW    = 6;
    localparam int NPIX  = W*H;
    localparam int NPOOL = (W/2)*(H/2);
    localparam longint MAXV = (longint'(1) << (DW-1)) - 1;

    typedef struct {
        logic [2:0]    sel;
        int            addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk;
    logic          reset;
    logic          ready;
    logic          busy;
    logic          pool_en;
    logic          coef_we;
    logic [3:0]    coef_idx;
    logic [DW-1:0] coef_data;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic [2:0]    csel;

    logic [DW-1:0]        img  [NPIX];
    logic [DW-1:0]        map0 [NPIX];
    logic [DW-1:0]        map1 [NPOOL];
    logic [DW-1:0]        exp0 [NPIX];
    logic signed [DW-1:0] k_m  [9];
    logic signed [DW-1:0] b_m;
    wr_t                  exp_q [$];

    int checks;
    int errors;
    int busy_cycles;

    conv_pool_engine #(
        .IMG_W(W), .IMG_H(H), .DW(DW), .FRAC(FRAC), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .ready(ready), .busy(busy), .pool_en(pool_en),
        .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
        .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Image ROM and map RAM with one-cycle read latency.
    always @(posedge clk) begin
        idata    <= (int'(iaddr) < NPIX) ? img[iaddr] : '0;
        cdata_rd <= (int'(caddr_rd) < NPIX) ? map0[caddr_rd] : '0;
        if (cwr && csel == 3'b001 && int'(caddr_wr) < NPIX) map0[caddr_wr] <= cdata_wr;
        if (cwr && csel == 3'b011 && int'(caddr_wr) < NPOOL) map1[caddr_wr] <= cdata_wr;
    end

    function automatic logic [DW-1:0] conv_ref(input int x, input int y);
        longint acc;
        longint r;
        int xx;
        int yy;
        acc = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                xx = x + dx;
                yy = y + dy;
                if (xx >= 0 && xx < W && yy >= 0 && yy < H)
                    acc += longint'($signed(img[yy*W+xx])) * longint'(k_m[(dy+1)*3 + dx + 1]);
            end
        end
        r = (acc + longint'(b_m) * (longint'(1) << FRAC) + (longint'(1) << (FRAC-1))) >>> FRAC;
        if (r < 0) r = 0;
        if (r > MAXV) r = MAXV;
        return r[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rand_fix(input int range);
        int v;
        v = int'($urandom_range(0, 2*range)) - range;
        return DW'(v);
    endfunction

    task automatic build_expected(input logic pool);
        logic [DW-1:0] m;
        logic [DW-1:0] v;
        exp_q.delete();
        for (int a = 0; a < NPIX; a++) begin
            exp0[a] = conv_ref(a % W, a / W);
            exp_q.push_back('{3'b001, a, exp0[a]});
        end
        if (pool) begin
            for (int p = 0; p < NPOOL; p++) begin
                m = '0;
                for (int q = 0; q < 4; q++) begin
                    v = exp0[(2*(p/(W/2)) + q/2)*W + 2*(p%(W/2)) + q%2];
                    if (v > m) m = v;
                end
                exp_q.push_back('{3'b011, p, m});
            end
        end
    endtask

    task automatic check_word(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    task automatic load_coef(input logic [3:0] idx, input logic [DW-1:0] data);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_idx  = idx;
        coef_data = data;
        if (idx < 4'd9) k_m[idx] = data;
        else if (idx == 4'd9) b_m = data;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic load_all(input logic [DW-1:0] edge_v, input logic [DW-1:0] center_v,
                            input logic [DW-1:0] bias_v);
        for (int i = 0; i < 9; i++) load_coef(4'(i), (i == 4) ? center_v : edge_v);
        load_coef(4'd9, bias_v);
    endtask

    task automatic fill_img_const(input logic [DW-1:0] v);
        for (int a = 0; a < NPIX; a++) img[a] = v;
    endtask

    task automatic clear_maps();
        for (int a = 0; a < NPIX; a++) map0[a] = 20'hAAAAA;
        for (int a = 0; a < NPOOL; a++) map1[a] = 20'hAAAAA;
    endtask

    task automatic run_image(input logic pool, input bit poke);
        int n;
        int want;
        clear_maps();
        build_expected(pool);
        want = NPIX*12 + (pool ? NPOOL*6 : 0);
        @(negedge clk);
        busy_cycles = 0;
        pool_en = pool;
        ready   = 1'b1;
        @(negedge clk);
        ready   = 1'b0;
        pool_en = 1'b0;
        n = 0;
        while (busy && n < want + 50) begin
            if (poke && n == 100) begin
                coef_we   = 1'b1;
                coef_idx  = 4'd4;
                coef_data = 20'h12345;
            end else if (poke && n == 101) begin
                coef_idx  = 4'd9;
                coef_data = 20'h54321;
            end else begin
                coef_we = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        coef_we = 1'b0;
        checks++;
        if (busy) begin
            errors++;
            $display("[TB] FAIL run_timeout busy still high after %0d cycles", n);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL missing_writes got %0d outstanding expected 0", exp_q.size());
        end
        checks++;
        if (busy_cycles != want) begin
            errors++;
            $display("[TB] FAIL busy_length got %0d expected %0d", busy_cycles, want);
        end
    endtask

    // Compare process: every write is matched against the model's ordered write list.
    always @(negedge clk) begin
        wr_t e;
        if (reset) begin
            checks++;
            if (busy || cwr || crd || csel != 3'b000 || iaddr != '0) begin
                errors++;
                $display("[TB] FAIL reset_outputs busy=%b cwr=%b crd=%b csel=%b iaddr=%0d expected all 0",
                         busy, cwr, crd, csel, iaddr);
            end
        end else begin
            if (busy) busy_cycles++;
            if (cwr) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_write got sel=%b addr=%0d data=%h expected none",
                             csel, caddr_wr, cdata_wr);
                end else begin
                    e = exp_q.pop_front();
                    if (crd || csel !== e.sel || int'(caddr_wr) != e.addr || cdata_wr !== e.data) begin
                        errors++;
                        $display("[TB] FAIL map_write got sel=%b addr=%0d data=%h crd=%b expected sel=%b addr=%0d data=%h crd=0",
                                 csel, caddr_wr, cdata_wr, crd, e.sel, e.addr, e.data);
                    end
                end
            end
            if (crd) begin
                checks++;
                if (csel !== 3'b001) begin
                    errors++;
                    $display("[TB] FAIL read_csel got %b expected 001", csel);
                end
            end
            if (!busy) begin
                checks++;
                if (cwr || crd || csel != 3'b000) begin
                    errors++;
                    $display("[TB] FAIL idle_outputs got cwr=%b crd=%b csel=%b expected 0", cwr, crd, csel);
                end
            end
        end
    end

    initial begin
        checks      = 0;
        errors      = 0;
        busy_cycles = 0;
        reset       = 1'b1;
        ready       = 1'b0;
        pool_en     = 1'b0;
        coef_we     = 1'b0;
        coef_idx    = '0;
        coef_data   = '0;
        for (int i = 0; i < 9; i++) k_m[i] = '0;
        b_m = '0;
        fill_img_const('0);
        clear_maps();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Bias only: every word equals the bias.
        load_all('0, '0, 20'h01000);
        run_image(1'b1, 1'b0);
        check_word("biasonly_l0_0", map0[0], 20'h01000);
        check_word("biasonly_l0_last", map0[NPIX-1], 20'h01000);
        check_word("biasonly_l1_0", map1[0], 20'h01000);

        // Identity kernel on a ramp image.
        load_all('0, 20'h10000, '0);
        for (int a = 0; a < NPIX; a++) img[a] = DW'(a);
        run_image(1'b1, 1'b0);
        check_word("ident_corner0", map0[0], 20'd0);
        check_word("ident_corner1", map0[W-1], DW'(W-1));
        check_word("ident_corner2", map0[NPIX-W], DW'(NPIX-W));
        check_word("ident_corner3", map0[NPIX-1], DW'(NPIX-1));
        check_word("ident_pool0", map1[0], DW'(W+1));
        check_word("ident_pool_last", map1[NPOOL-1], DW'(NPIX-1));

        // All-ones kernel: padding counts at corners and edges, interior saturates.
        load_all(20'h10000, 20'h10000, '0);
        fill_img_const(20'h10000);
        run_image(1'b1, 1'b0);
        check_word("ones_corner", map0[0], 20'h40000);
        check_word("ones_top_edge", map0[1], 20'h60000);
        check_word("ones_left_edge", map0[W], 20'h60000);
        check_word("ones_interior_sat", map0[W+1], 20'h7FFFF);
        check_word("ones_last_corner", map0[NPIX-1], 20'h40000);
        check_word("ones_pool0", map1[0], 20'h7FFFF);

        // Negative weight is clipped by ReLU.
        load_all('0, 20'hF0000, '0);
        run_image(1'b1, 1'b0);
        check_word("relu_0", map0[0], 20'd0);
        check_word("relu_mid", map0[W+3], 20'd0);

        // Half weight on one LSB rounds up; conv only with a coefficient write attempted while busy.
        load_all('0, 20'h08000, '0);
        fill_img_const(20'h00001);
        run_image(1'b0, 1'b1);
        check_word("round_0", map0[0], 20'h00001);
        check_word("round_mid", map0[W+2], 20'h00001);
        check_word("no_l1_write", map1[0], 20'hAAAAA);
        run_image(1'b0, 1'b0);
        check_word("coef_kept", map0[NPIX-1], 20'h00001);

        // Random coefficients and images.
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 9; i++) load_coef(4'(i), rand_fix(32'h10000));
            load_coef(4'd9, rand_fix(32'h8000));
            for (int a = 0; a < NPIX; a++) img[a] = rand_fix(32'h20000);
            run_image(1'($urandom_range(0, 1)), 1'b0);
        end

        // Abort mid-run, then confirm coefficients were cleared and a reload restarts cleanly.
        load_all(20'h04000, 20'h10000, 20'h00800);
        build_expected(1'b1);
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (100*12 % (NPIX*12) + 5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy || cwr || crd || csel != 3'b000 || caddr_wr != '0 || cdata_wr != '0) begin
            errors++;
            $display("[TB] FAIL abort_outputs busy=%b cwr=%b crd=%b csel=%b expected all 0", busy, cwr, crd, csel);
        end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) k_m[i] = '0;
        b_m = '0;
        repeat (5) @(negedge clk);
        run_image(1'b0, 1'b0);
        check_word("coef_reset_cleared", map0[W+1], 20'd0);
        load_all(20'h04000, 20'h10000, 20'h00800);
        for (int a = 0; a < NPIX; a++) img[a] = rand_fix(32'h20000);
        run_image(1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
